// File: rtl/robot_nav_pkg.sv
// Shared types for the waiter-robot navigation controller: motor command and
// state encodings, plus one-hot decoding of the camera zone vector.
package robot_nav_pkg;

    localparam int MAX_ZONES = 32;

    typedef enum logic [4:0] {
        MOTOR_STOP    = 5'b00001,
        MOTOR_FORWARD = 5'b00010,
        MOTOR_RIGHT   = 5'b00100,
        MOTOR_LEFT    = 5'b01000,
        MOTOR_SPIN    = 5'b10000
    } motor_state_t;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_SEARCH    = 4'd1,
        ST_FORWARD   = 4'd2,
        ST_LEFT      = 4'd3,
        ST_RIGHT     = 4'd4,
        ST_STOP      = 4'd5,
        ST_ARRIVED   = 4'd6,
        ST_WAIT_DEST = 4'd7,
        ST_RELAUNCH  = 4'd8,
        ST_ABORT     = 4'd9
    } nav_state_t;

    typedef enum logic [1:0] {
        ZONE_NONE,
        ZONE_RIGHT,
        ZONE_CENTRE,
        ZONE_LEFT
    } zone_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] index;
    } onehot_info_t;

    // valid only when exactly one bit is set; index is then that bit's position
    function automatic onehot_info_t onehot_decode(input logic [MAX_ZONES-1:0] vec);
        onehot_info_t info;
        int           ones;
        info.valid = 1'b0;
        info.index = '0;
        ones       = 0;
        for (int i = 0; i < MAX_ZONES; i++) begin
            if (vec[i]) begin
                ones       = ones + 1;
                info.index = 5'(i);
            end
        end
        info.valid = (ones == 1);
        return info;
    endfunction

endpackage

// File: rtl/nav_tick_gen.sv
// Free-running divider producing a single-cycle tick every TICK_DIV clocks,
// so the whole controller stays on one clock.
module nav_tick_gen #(
    parameter int TICK_DIV = 5000000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CW'(TICK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/robot_nav_fsm.sv
// Waiter-robot navigation FSM: steers toward the tracked colour zone, stops on
// debounced proximity, confirms arrival, and handles relaunch/abort flows.
module robot_nav_fsm
    import robot_nav_pkg::*;
#(
    parameter int NUM_ZONES      = 3,
    parameter int TICK_DIV       = 5000000,
    parameter int PROX_DEBOUNCE  = 2,
    parameter int ARRIVE_TICKS   = 3,
    parameter int SEARCH_TIMEOUT = 100
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bell,
    input  logic                 home_cmd,
    input  logic                 proximity,
    input  logic [NUM_ZONES-1:0] pixel_location,
    output logic                 overwrite,
    output logic [4:0]           motor_state,
    output logic [3:0]           state_code,
    output logic                 abort
);

    localparam int SW = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;
    localparam int AW = (ARRIVE_TICKS > 1) ? $clog2(ARRIVE_TICKS) : 1;
    localparam int PW = $clog2(PROX_DEBOUNCE + 1);

    localparam logic [SW-1:0] SEARCH_LAST = SW'(SEARCH_TIMEOUT - 1);
    localparam logic [AW-1:0] ARRIVE_LAST = AW'(ARRIVE_TICKS - 1);
    localparam logic [PW-1:0] PROX_FULL   = PW'(PROX_DEBOUNCE);
    localparam logic [4:0]    CENTRE_IDX  = 5'((NUM_ZONES - 1) / 2);

    logic tick;

    nav_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    nav_state_t    state_q, state_d;
    logic [SW-1:0] search_cnt_q, search_cnt_d;
    logic [AW-1:0] arr_cnt_q, arr_cnt_d;
    logic [PW-1:0] prox_cnt_q, prox_cnt_d;
    logic          bell_pend_q, bell_pend_d;
    logic          home_pend_q, home_pend_d;
    logic          overwrite_q, overwrite_d;

    logic                 prox_db;
    logic [MAX_ZONES-1:0] pix_ext;
    onehot_info_t         zinfo;
    zone_t                zone;

    assign prox_db = (prox_cnt_q == PROX_FULL);
    assign pix_ext = MAX_ZONES'(pixel_location);

    always_comb begin
        zinfo = onehot_decode(pix_ext);
        zone  = ZONE_NONE;
        if (zinfo.valid) begin
            if (zinfo.index < CENTRE_IDX) begin
                zone = ZONE_RIGHT;
            end else if (zinfo.index == CENTRE_IDX) begin
                zone = ZONE_CENTRE;
            end else begin
                zone = ZONE_LEFT;
            end
        end
    end

    function automatic nav_state_t steer_state(input zone_t z);
        case (z)
            ZONE_CENTRE: return ST_FORWARD;
            ZONE_RIGHT:  return ST_RIGHT;
            ZONE_LEFT:   return ST_LEFT;
            default:     return ST_SEARCH;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        search_cnt_d = search_cnt_q;
        arr_cnt_d    = arr_cnt_q;
        prox_cnt_d   = prox_cnt_q;
        overwrite_d  = overwrite_q;
        // pending flags are consumed on a tick unless the input is still held
        bell_pend_d  = bell | (bell_pend_q & ~tick);
        home_pend_d  = home_cmd | (home_pend_q & ~tick);

        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (bell_pend_q) state_d = ST_SEARCH;
                end
                ST_SEARCH: begin
                    if (zone != ZONE_NONE) begin
                        state_d = steer_state(zone);
                    end else if (search_cnt_q == SEARCH_LAST) begin
                        state_d = ST_ABORT;
                    end else begin
                        search_cnt_d = search_cnt_q + SW'(1);
                    end
                end
                ST_FORWARD, ST_LEFT, ST_RIGHT: begin
                    state_d = prox_db ? ST_STOP : steer_state(zone);
                end
                ST_STOP: begin
                    if (!prox_db) begin
                        state_d = ST_SEARCH;
                    end else if (zone == ZONE_CENTRE) begin
                        if (arr_cnt_q == ARRIVE_LAST) begin
                            state_d = ST_ARRIVED;
                        end else begin
                            arr_cnt_d = arr_cnt_q + AW'(1);
                        end
                    end else begin
                        arr_cnt_d = '0;
                    end
                end
                ST_ARRIVED:  state_d = ST_WAIT_DEST;
                ST_WAIT_DEST: begin
                    if (home_pend_q) begin
                        state_d = ST_IDLE;
                    end else if (bell_pend_q) begin
                        state_d = ST_RELAUNCH;
                    end
                end
                ST_RELAUNCH: state_d = ST_SEARCH;
                ST_ABORT: begin
                    if (home_pend_q) begin
                        state_d = ST_IDLE;
                    end else if (bell_pend_q) begin
                        state_d = ST_SEARCH;
                    end
                end
                default:     state_d = ST_IDLE;
            endcase

            if (state_d == ST_SEARCH && state_q != ST_SEARCH) search_cnt_d = '0;
            if (state_d == ST_STOP && state_q != ST_STOP)     arr_cnt_d    = '0;

            if (state_d == ST_RELAUNCH) begin
                overwrite_d = 1'b1;
            end else if (state_d == ST_IDLE) begin
                overwrite_d = 1'b0;
            end

            if (!proximity) begin
                prox_cnt_d = '0;
            end else if (!prox_db) begin
                prox_cnt_d = prox_cnt_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            search_cnt_q <= '0;
            arr_cnt_q    <= '0;
            prox_cnt_q   <= '0;
            bell_pend_q  <= 1'b0;
            home_pend_q  <= 1'b0;
            overwrite_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            search_cnt_q <= search_cnt_d;
            arr_cnt_q    <= arr_cnt_d;
            prox_cnt_q   <= prox_cnt_d;
            bell_pend_q  <= bell_pend_d;
            home_pend_q  <= home_pend_d;
            overwrite_q  <= overwrite_d;
        end
    end

    always_comb begin
        case (state_q)
            ST_SEARCH:  motor_state = MOTOR_SPIN;
            ST_FORWARD: motor_state = MOTOR_FORWARD;
            ST_LEFT:    motor_state = MOTOR_LEFT;
            ST_RIGHT:   motor_state = MOTOR_RIGHT;
            default:    motor_state = MOTOR_STOP;
        endcase
    end

    assign state_code = state_q;
    assign abort      = (state_q == ST_ABORT);
    assign overwrite  = overwrite_q;

endmodule

// File: tb/tb_robot_nav_fsm.sv
// Bench for robot_nav_fsm: directed walk through the navigation flows, then
// random stimulus, all compared every clock against a behavioural model.
module tb_robot_nav_fsm;

    localparam int NZ = 5;
    localparam int TD = 4;
    localparam int PD = 2;
    localparam int AT = 3;
    localparam int ST = 6;

    localparam int S_IDLE = 0, S_SEARCH = 1, S_FWD = 2, S_LEFT = 3, S_RIGHT = 4;
    localparam int S_STOP = 5, S_ARRIVED = 6, S_WAIT = 7, S_RELAUNCH = 8, S_ABORT = 9;
    localparam int Z_NONE = 0, Z_RIGHT = 1, Z_CENTRE = 2, Z_LEFT = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          bell;
    logic          home_cmd;
    logic          proximity;
    logic [NZ-1:0] pixel_location;
    logic          overwrite;
    logic [4:0]    motor_state;
    logic [3:0]    state_code;
    logic          abort;

    robot_nav_fsm #(
        .NUM_ZONES      (NZ),
        .TICK_DIV       (TD),
        .PROX_DEBOUNCE  (PD),
        .ARRIVE_TICKS   (AT),
        .SEARCH_TIMEOUT (ST)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bell           (bell),
        .home_cmd       (home_cmd),
        .proximity      (proximity),
        .pixel_location (pixel_location),
        .overwrite      (overwrite),
        .motor_state    (motor_state),
        .state_code     (state_code),
        .abort          (abort)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // behavioural model
    int m_div       = 0;
    int m_state     = S_IDLE;
    int m_prox_run  = 0;
    int m_nones     = 0;
    int m_centred   = 0;
    bit m_bell      = 1'b0;
    bit m_home      = 1'b0;
    bit m_ov        = 1'b0;
    bit m_tick      = 1'b0;

    function automatic int zone_of(input logic [NZ-1:0] p);
        int pos;
        pos = 0;
        if ($countones(p) != 1) return Z_NONE;
        for (int i = 0; i < NZ; i++) if (p[i]) pos = i;
        if (pos < (NZ - 1) / 2) return Z_RIGHT;
        if (pos == (NZ - 1) / 2) return Z_CENTRE;
        return Z_LEFT;
    endfunction

    function automatic int steer(input int z);
        if (z == Z_CENTRE) return S_FWD;
        if (z == Z_RIGHT) return S_RIGHT;
        if (z == Z_LEFT) return S_LEFT;
        return S_SEARCH;
    endfunction

    function automatic int motor_of(input int s);
        case (s)
            S_SEARCH: return 16;
            S_FWD:    return 2;
            S_RIGHT:  return 4;
            S_LEFT:   return 8;
            default:  return 1;
        endcase
    endfunction

    task automatic model_edge();
        int  nxt;
        int  z;
        bit  near;
        if (reset) begin
            m_div = 0; m_state = S_IDLE; m_prox_run = 0; m_nones = 0; m_centred = 0;
            m_bell = 0; m_home = 0; m_ov = 0; m_tick = 0;
        end else begin
            m_tick = (m_div == TD - 1);
            m_div  = m_tick ? 0 : m_div + 1;
            if (m_tick) begin
                near = (m_prox_run >= PD);
                z    = zone_of(pixel_location);
                nxt  = m_state;
                case (m_state)
                    S_IDLE:   if (m_bell) nxt = S_SEARCH;
                    S_SEARCH: begin
                        if (z != Z_NONE) nxt = steer(z);
                        else begin
                            m_nones++;
                            if (m_nones == ST) nxt = S_ABORT;
                        end
                    end
                    S_FWD, S_LEFT, S_RIGHT: nxt = near ? S_STOP : steer(z);
                    S_STOP: begin
                        if (!near) nxt = S_SEARCH;
                        else if (z == Z_CENTRE) begin
                            m_centred++;
                            if (m_centred == AT) nxt = S_ARRIVED;
                        end else m_centred = 0;
                    end
                    S_ARRIVED:  nxt = S_WAIT;
                    S_WAIT:     nxt = m_home ? S_IDLE : (m_bell ? S_RELAUNCH : S_WAIT);
                    S_RELAUNCH: nxt = S_SEARCH;
                    S_ABORT:    nxt = m_home ? S_IDLE : (m_bell ? S_SEARCH : S_ABORT);
                    default:    nxt = S_IDLE;
                endcase
                if (nxt == S_SEARCH && m_state != S_SEARCH) m_nones = 0;
                if (nxt == S_STOP && m_state != S_STOP) m_centred = 0;
                if (nxt == S_RELAUNCH) m_ov = 1;
                else if (nxt == S_IDLE) m_ov = 0;
                m_state    = nxt;
                m_prox_run = proximity ? ((m_prox_run < 1000) ? m_prox_run + 1 : m_prox_run) : 0;
            end
            m_bell = bell | (m_bell & !m_tick);
            m_home = home_cmd | (m_home & !m_tick);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("state_code", 32'(state_code), 32'(m_state));
        chk("motor_state", 32'(motor_state), 32'(motor_of(m_state)));
        chk("overwrite", 32'(overwrite), 32'(m_ov));
        chk("abort", 32'(abort), 32'(m_state == S_ABORT));
        chk("tick", 32'(dut.u_tick_gen.tick), 32'(m_div == TD - 1));
    endtask

    task automatic run_ticks(input int n);
        int seen;
        int budget;
        seen   = 0;
        budget = n * TD + TD;
        while (seen < n && budget > 0) begin
            step();
            if (m_tick) seen++;
            budget--;
        end
        if (seen < n) begin
            failures++;
            $error("FAIL run_ticks_timeout observed=%0d expected=%0d", seen, n);
        end
    endtask

    // leaves the bench in the cycle right after a tick edge
    task automatic align();
        int budget;
        budget = TD + 1;
        step();
        while (m_div != 0 && budget > 0) begin
            step();
            budget--;
        end
    endtask

    task automatic pulse(input bit b, input bit h);
        align();
        bell     = b;
        home_cmd = h;
        step();
        bell     = 1'b0;
        home_cmd = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1; bell = 1'b0; home_cmd = 1'b0; proximity = 1'b0; pixel_location = '0;
        repeat (3) step();
        chk("reset_state", 32'(state_code), 32'd0);
        chk("reset_motor", 32'(motor_state), 32'b00001);
        chk("reset_overwrite", 32'(overwrite), 32'd0);
        reset = 1'b0;
        repeat (20) step();
        chk("idle_state", 32'(state_code), 32'd0);

        pulse(1'b1, 1'b0);
        run_ticks(1);
        chk("bell_search", 32'(state_code), 32'd1);
        chk("bell_spin", 32'(motor_state), 32'b10000);
        pixel_location = 5'b00100; run_ticks(1);
        chk("centre_fwd", 32'(motor_state), 32'b00010);
        pixel_location = 5'b00001; run_ticks(1);
        chk("zone0_right", 32'(motor_state), 32'b00100);
        pixel_location = 5'b10000; run_ticks(1);
        chk("zone4_left", 32'(motor_state), 32'b01000);
        pixel_location = 5'b00110; run_ticks(1);
        chk("multi_search", 32'(state_code), 32'd1);

        pixel_location = 5'b00100; run_ticks(1);
        proximity = 1'b1; run_ticks(1);
        proximity = 1'b0; run_ticks(2);
        chk("prox_glitch_fwd", 32'(state_code), 32'd2);
        proximity = 1'b1; run_ticks(3);
        chk("prox_stop", 32'(state_code), 32'd5);
        chk("prox_stop_motor", 32'(motor_state), 32'b00001);
        run_ticks(3);
        chk("arrived", 32'(state_code), 32'd6);
        run_ticks(1);
        chk("wait_dest", 32'(state_code), 32'd7);

        pulse(1'b1, 1'b0);
        run_ticks(1);
        chk("relaunch", 32'(state_code), 32'd8);
        chk("relaunch_ov", 32'(overwrite), 32'd1);
        run_ticks(1);
        chk("relaunch_search_ov", 32'(overwrite), 32'd1);
        run_ticks(6);
        chk("wait_dest2", 32'(state_code), 32'd7);
        pulse(1'b0, 1'b1);
        run_ticks(1);
        chk("home_idle", 32'(state_code), 32'd0);
        chk("home_ov_clr", 32'(overwrite), 32'd0);

        proximity = 1'b0; pixel_location = '0;
        pulse(1'b1, 1'b0);
        run_ticks(1);
        run_ticks(6);
        chk("abort_state", 32'(state_code), 32'd9);
        chk("abort_flag", 32'(abort), 32'd1);
        chk("abort_motor", 32'(motor_state), 32'b00001);
        pulse(1'b1, 1'b1);
        run_ticks(1);
        chk("abort_both_idle", 32'(state_code), 32'd0);
        run_ticks(2);
        chk("pend_cleared", 32'(state_code), 32'd0);

        pixel_location = 5'b10000;
        pulse(1'b1, 1'b0);
        run_ticks(2);
        chk("left_before_reset", 32'(state_code), 32'd3);
        step();
        reset = 1'b1;
        step();
        chk("midreset_state", 32'(state_code), 32'd0);
        chk("midreset_motor", 32'(motor_state), 32'b00001);
        reset = 1'b0;
        n = 0;
        while (dut.u_tick_gen.tick !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        chk("first_tick_after_reset", 32'(n), 32'd3);

        for (int i = 0; i < 3000; i++) begin
            int r;
            bell     = ($urandom_range(0, 29) == 0);
            home_cmd = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 7) == 0) proximity = ~proximity;
            if ($urandom_range(0, 5) == 0) begin
                r = $urandom_range(0, 9);
                if (r < NZ) pixel_location = NZ'(1 << r);
                else if (r < 7) pixel_location = 5'b00100;
                else if (r == 7) pixel_location = '0;
                else pixel_location = NZ'($urandom);
            end
            reset = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
